// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter with a one-byte holding register for back-to-back frames.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit, giving 11-bit frames.
module uart_tx_serializer #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       busy
);

  // state  | meaning
  // IDLE   | line high, waiting for the holding register to fill
  // START  | start bit (0)
  // DATA   | eight data bits, LSB first
  // PARITY | even parity over the data byte (parity build only)
  // STOP   | stop bit (1); chains straight into START when a byte is waiting

  localparam int BIT_TICKS = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_TICKS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       idx_inc;
  logic [7:0]       frame_q, frame_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             txd_q, txd_d;
  logic             ready_q;
  logic             accept;
  logic             bit_done;
  logic             load;

  assign accept   = tx_valid && ready_q;
  assign bit_done = (cnt_q == '0);
  assign idx_inc  = idx_q + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      ready_q     <= ~hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = txd_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = CNT_RELOAD;
          idx_d   = '0;
          txd_d   = frame_q[0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = CNT_RELOAD;
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = ^frame_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_inc;
            txd_d = frame_q[idx_inc];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          cnt_d   = CNT_RELOAD;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase

    // A transfer and a fresh accept on the same edge leave the holding register full.
    if (load) begin
      state_d     = START;
      frame_d     = hold_q;
      txd_d       = 1'b0;
      cnt_d       = CNT_RELOAD;
      idx_d       = '0;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign busy     = (state_q != IDLE) || hold_full_q;

endmodule
